// File: rtl/vdp_bus_ifce.sv
// -----------------------------------------------------------------------------
// vdp_bus_ifce
//
// CPU-side front end for the vdp99 core. Decodes the Z8S180 I/O strobes for
// the VDP port pair, synchronises them into the pxclk domain, and turns each
// CPU bus cycle into exactly one single-cycle wr_tick or rd_tick. During a
// read it captures vdp99's dout for the CPU, and it holds WAIT low until that
// data is ready.
//
// Parameters
//   PORT_BASE   : I/O address of the port pair. Bit 0 is ignored, and A0
//                 selects the mode (0 = VRAM data, 1 = register/status).
//   SYNC_STAGES : depth of the strobe synchronisers (2..3).
//
// Ports
//   pxclk, reset_n          : clock and asynchronous active-low reset
//   bus_a, bus_d_in         : CPU address and write data (asynchronous)
//   bus_iorq_n/rd_n/wr_n    : CPU I/O strobes, active low (asynchronous)
//   bus_m1_n                : CPU M1; IORQ together with M1 is an interrupt ack
//   bus_d_out, bus_d_oe     : read data and its output enable toward the CPU
//   bus_wait_n              : CPU WAIT, active low (combinational)
//   vdp_dout                : vdp99 read data, valid during rd_tick
//   wr_tick, rd_tick        : one-pxclk access strobes to vdp99
//   mode, din               : latched A0 and latched write data for vdp99
// -----------------------------------------------------------------------------
module vdp_bus_ifce #(
    parameter logic [7:0] PORT_BASE   = 8'h98,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       pxclk,
    input  logic       reset_n,
    input  logic [7:0] bus_a,
    input  logic [7:0] bus_d_in,
    input  logic       bus_iorq_n,
    input  logic       bus_rd_n,
    input  logic       bus_wr_n,
    input  logic       bus_m1_n,
    output logic [7:0] bus_d_out,
    output logic       bus_d_oe,
    output logic       bus_wait_n,
    input  logic [7:0] vdp_dout,
    output logic       wr_tick,
    output logic       rd_tick,
    output logic       mode,
    output logic [7:0] din
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("vdp_bus_ifce: SYNC_STAGES must be 2 or 3");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TICK_W = 2'd1,
        ST_TICK_R = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic                   r_ready;

    logic w_sel_raw;
    logic w_rd_req_n;
    logic w_wr_req_n;
    logic w_s_rd;
    logic w_s_wr;
    logic w_start_wr;
    logic w_start_rd;

    // The select is purely combinational on the asynchronous bus. It is only
    // consumed by the FSM after the synchronised strobe has arrived, and by
    // then the address and M1 have long been stable.
    assign w_sel_raw = !bus_iorq_n && bus_m1_n && (bus_a[7:1] == PORT_BASE[7:1]);

    // The strobes are synchronised in active-low form. This way the reset
    // value of all ones means "no access" rather than a phantom request.
    assign w_rd_req_n = bus_iorq_n || bus_rd_n;
    assign w_wr_req_n = bus_iorq_n || bus_wr_n;

    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every flop samples the pre-edge value of its neighbour, which is what
    // makes a shift-register synchroniser work.
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_sync <= '1;
            r_wr_sync <= '1;
        end else begin
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], w_rd_req_n};
            r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], w_wr_req_n};
        end
    end

    assign w_s_rd = !r_rd_sync[SYNC_STAGES-1];
    assign w_s_wr = !r_wr_sync[SYNC_STAGES-1];

    assign w_start_wr = w_s_wr && !w_s_rd && w_sel_raw;
    assign w_start_rd = w_s_rd && !w_s_wr && w_sel_raw;

    // State register
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. DONE is only left once both synced strobes are low,
    // so a strobe held for any length of time produces a single tick.
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_wr) begin
                    w_next_state = ST_TICK_W;
                end else if (w_start_rd) begin
                    w_next_state = ST_TICK_R;
                end else if (w_s_rd || w_s_wr) begin
                    // This covers an off-port access, an interrupt ack, or
                    // RD and WR low together. It is absorbed without a tick.
                    w_next_state = ST_DONE;
                end
            end
            ST_TICK_W: w_next_state = ST_DONE;
            ST_TICK_R: w_next_state = ST_DONE;
            ST_DONE: begin
                if (!w_s_rd && !w_s_wr) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        wr_tick = 1'b0;
        rd_tick = 1'b0;
        case (r_state)
            ST_TICK_W: wr_tick = 1'b1;
            ST_TICK_R: rd_tick = 1'b1;
            default: ;
        endcase
    end

    // Datapath latches and the ready flag. ready tracks DONE exactly: it is
    // set on entry and cleared on the return to IDLE.
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            din       <= 8'h00;
            mode      <= 1'b0;
            bus_d_out <= 8'h00;
            r_ready   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_start_wr) begin
                din  <= bus_d_in;
                mode <= bus_a[0];
            end else if (r_state == ST_IDLE && w_start_rd) begin
                mode <= bus_a[0];
            end
            if (r_state == ST_TICK_R) begin
                bus_d_out <= vdp_dout;
            end
            r_ready <= (w_next_state == ST_DONE);
        end
    end

    // WAIT has to assert within gate delay of the strobe, so it cannot wait
    // for the synchronisers. The reset term releases the CPU at once while
    // reset_n is low.
    assign bus_wait_n = !(reset_n && w_sel_raw && (!bus_rd_n || !bus_wr_n) && !r_ready);
    assign bus_d_oe   = w_sel_raw && !bus_rd_n && r_ready;

endmodule
